// File: rtl/cnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_pkg : shared CNN front-end types and default image geometry  rev 1.0 |
// +--------------------------------------------------------------------------+
package cnn_pkg;

  localparam int DEFAULT_IMAGE_WIDTH  = 12;
  localparam int DEFAULT_IMAGE_HEIGHT = 12;
  localparam int DEFAULT_PIXEL_WIDTH  = 2;
  localparam int DEFAULT_COUNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } loader_state_t;

  typedef logic signed [DEFAULT_PIXEL_WIDTH-1:0] pixel_t;

  // Index width that stays at least one bit for degenerate dimensions.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_image_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_image_loader_if : valid/ready pixel stream                   rev 1.0 |
// +--------------------------------------------------------------------------+
interface cnn_image_loader_if
  import cnn_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH
);
  logic                   pix_valid;
  logic                   pix_ready;
  logic [PIXEL_WIDTH-1:0] pix_data;
  logic                   pix_last;

  modport master (output pix_valid, pix_data, pix_last, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_last, output pix_ready);
endinterface
`default_nettype wire

// File: rtl/pixel_position_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_position_counter : row-major row/col tracker with wrap     rev 1.0 |
// +--------------------------------------------------------------------------+
module pixel_position_counter
  import cnn_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
  parameter int ROW_W        = idx_width(IMAGE_HEIGHT),
  parameter int COL_W        = idx_width(IMAGE_WIDTH)
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              clear,
  input  wire              inc,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             is_last_position
);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMAGE_WIDTH - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign is_last_position = (row == ROW_MAX) && (col == COL_MAX);

endmodule
`default_nettype wire

// File: rtl/cnn_image_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn_image_loader : pixel stream -> parallel image + CNN start    rev 1.0 |
// +--------------------------------------------------------------------------+
module cnn_image_loader
  import cnn_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
  parameter int PIXEL_WIDTH  = DEFAULT_PIXEL_WIDTH,
  parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
  input  wire                                              clk,
  input  wire                                              rst,
  cnn_image_loader_if.slave                                pix,
  output logic [IMAGE_HEIGHT*IMAGE_WIDTH*PIXEL_WIDTH-1:0]  image_output,
  output logic                                             convolution_enable,
  input  wire                                              cnn_done,
  output logic                                             frame_error,
  output logic [COUNT_WIDTH-1:0]                           frame_count
);
  localparam int IMG_BITS = IMAGE_HEIGHT * IMAGE_WIDTH * PIXEL_WIDTH;
  localparam int ROW_W    = idx_width(IMAGE_HEIGHT);
  localparam int COL_W    = idx_width(IMAGE_WIDTH);
  localparam int LSB_W    = idx_width(IMG_BITS);

  loader_state_t    state;
  loader_state_t    state_next;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [LSB_W-1:0] pixel_lsb;
  logic             is_last_position;
  logic             accept;
  logic             pos_clear;
  logic             pos_inc;
  logic             err_set;
  logic             count_inc;

  // Ready comes from registered state only; rst gates it so nothing is taken mid-reset.
  assign pix.pix_ready = (state == LOAD) && !rst;
  assign accept        = pix.pix_valid && pix.pix_ready;

  pixel_position_counter #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT),
    .ROW_W        (ROW_W),
    .COL_W        (COL_W)
  ) u_pos (
    .clk              (clk),
    .rst              (rst),
    .clear            (pos_clear),
    .inc              (pos_inc),
    .row              (row),
    .col              (col),
    .is_last_position (is_last_position)
  );

  always_comb begin
    state_next = state;
    pos_clear  = 1'b0;
    pos_inc    = 1'b0;
    err_set    = 1'b0;
    count_inc  = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          if (is_last_position) begin
            // A full frame is delivered even when its last marker is missing.
            state_next = START;
            pos_clear  = 1'b1;
            err_set    = !pix.pix_last;
          end else if (pix.pix_last) begin
            pos_clear = 1'b1;
            err_set   = 1'b1;
          end else begin
            pos_inc = 1'b1;
          end
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (cnn_done) begin
          state_next = LOAD;
          pos_clear  = 1'b1;
          count_inc  = 1'b1;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= LOAD;
      convolution_enable <= 1'b1;
      frame_error        <= 1'b0;
      frame_count        <= '0;
    end else begin
      state              <= state_next;
      convolution_enable <= (state_next != START);
      if (err_set) frame_error <= 1'b1;
      if (count_inc) frame_count <= frame_count + COUNT_WIDTH'(1);
    end
  end

  assign pixel_lsb = LSB_W'((int'(row) * IMAGE_WIDTH + int'(col)) * PIXEL_WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      image_output <= '0;
    end else if (accept) begin
      image_output[pixel_lsb +: PIXEL_WIDTH] <= pix.pix_data;
    end
  end

endmodule
`default_nettype wire

// File: doc/cnn_image_loader.md
Name: cnn_image_loader

Overview:
Upstream front-end of the CNN top.
- Accepts a 2D input image as a serial valid/ready pixel stream in row-major order.
- Assembles the pixels into the parallel image array the CNN consumes.
- Issues the CNN's active-low one-cycle convolution start pulse.
- Holds the image stable until the CNN reports completion.
- Replaces file/bench-driven image loading with a synthesizable path.

Parameters:
IMAGE_WIDTH, 12, pixels per row
IMAGE_HEIGHT, 12, rows per image
PIXEL_WIDTH, 2, signed pixel width in bits
COUNT_WIDTH, 16, width of completed-frame counter

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
pix_valid  in  1  stream pixel valid
pix_ready  out  1  loader can accept a pixel
pix_data  in  PIXEL_WIDTH  signed pixel value
pix_last  in  1  marks final pixel of a frame
image_output  out  IMAGE_HEIGHT*IMAGE_WIDTH*PIXEL_WIDTH  packed image; pixel [r][c] at bits (r*IMAGE_WIDTH+c)*PIXEL_WIDTH upward
convolution_enable  out  1  active-low start pulse to CNN
cnn_done  in  1  one-cycle pulse from CNN when it returns to IDLE
frame_error  out  1  sticky framing error flag
frame_count  out  COUNT_WIDTH  completed frames, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state=LOAD, row=col=0.
  - image_output all zero.
  - convolution_enable=1, frame_error=0, frame_count=0.
  - pix_ready=0 while rst is high.
- States:
  - LOAD: pix_ready=1. A beat is accepted when pix_valid & pix_ready. Accepted pixel is written to [row][col]. col increments; at IMAGE_WIDTH-1 it wraps to 0 and row increments.
  - START: pix_ready=0, convolution_enable=0 for exactly this one cycle. Unconditionally go to WAIT.
  - WAIT: pix_ready=0, convolution_enable=1, image_output frozen. On cnn_done: frame_count+1, row=col=0, go to LOAD.
- pix_ready is decoded from registered state only, with no combinational path from pix_valid.
- Latency: final pixel accepted at edge N → state START after N → convolution_enable low from edge N to edge N+1.
- Early pix_last (accepted beat with pix_last=1 at index < H*W-1):
  - frame_error set.
  - row=col=0, frame discarded, stay in LOAD.
  - Already-written pixels are not cleared.
- Missing pix_last (beat at index H*W-1 with pix_last=0): frame_error set, frame still delivered (go to START).
- cnn_done in LOAD or START: ignored.
- pix_valid in START or WAIT: not accepted; the stream stalls with data held by the source.
- frame_error: cleared only by rst.
- rst in any state, including START: wins over everything. Ongoing frame is aborted and convolution_enable is driven 1 in the same clocked update.
- frame_count: wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- Pixel values are stored verbatim. There is no sign extension; the CNN interprets them as signed PIXEL_WIDTH values.

Decomposition:
- cnn_pkg (shared package) contains:
  - loader_state_t enum {LOAD, START, WAIT}
  - pixel_t typedef (signed [PIXEL_WIDTH-1:0])
  - default image dimension constants, shared with the CNN top and the bench
- One sub-module: pixel_position_counter.
  - row/col counters with wrap, clear, and increment enable.
  - Outputs is_last_position = (row==H-1 && col==W-1).

Test Plan:
1. 144 pixels, value (i%3)-1, no gaps, pix_last on beat 143 → image_output[0][0]=-1, [0][1]=0, [11][11]=1; convolution_enable low exactly 1 cycle, the cycle after beat 143; pix_ready=0 until cnn_done.
2. Same frame with pix_valid toggled every other cycle → identical image_output; start pulse one cycle after the last accept.
3. pix_last on beat 50 → frame_error=1, no start pulse, next full 144-beat frame loads from [0][0] and pulses start once.
4. 144 beats with no pix_last → frame_error=1, start pulse still issued; cnn_done → frame_count=1.
5. cnn_done pulsed during LOAD and in the START cycle → ignored; state reaches WAIT and frame_count increments only on a cnn_done in WAIT.
6. rst high for 1 cycle while in WAIT with frame_count=3 → all outputs return to reset values; next frame loads normally, and frame_count=1 after its cnn_done.
